// File: rtl/vedic_dot_product_pkg.sv
// Shared constants for the vedic dot-product datapath.
// Operand/product widths are fixed by the vedic_8X8 multiplier. The
// accumulator and element-counter defaults are the widths the top uses
// when it is not overridden. Signed or MAC variants are expected to
// import this package as well.
package vedic_dot_product_pkg;
   localparam int OPND_W    = 8;
   localparam int PROD_W    = 16;
   localparam int ACC_W_DEF = 24;
   localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/vedic_dot_product_if.sv
// Operand/result stream bundle for vedic_dot_product.
//   in_valid/in_ready   operand-pair handshake
//   in_a, in_b          unsigned operands
//   in_last             pair closes the current vector
//   out_valid/out_ready result handshake
//   out_sum             accumulated dot product (wraps at ACC_W bits)
//   out_count           elements in the vector (saturating)
//   out_ovf             the sum wrapped at least once in the vector
// The slave modport is the engine's view; master is the producer/consumer view.
interface vedic_dot_product_if
   import vedic_dot_product_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
);
   logic              in_valid;
   logic              in_ready;
   logic [OPND_W-1:0] in_a;
   logic [OPND_W-1:0] in_b;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_sum;
   logic [CNT_W-1:0]  out_count;
   logic              out_ovf;

   modport slave (
      input  in_valid, in_a, in_b, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_ovf
   );

   modport master (
      output in_valid, in_a, in_b, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_count, out_ovf
   );
endinterface

// File: rtl/vedic_8X8.sv
// Combinational unsigned 8x8 multiplier built the Vedic (Urdhva
// Tiryakbhyam) way: 2x2 cells form 4x4 blocks, and four 4x4 blocks form
// the 8x8 product.
//   a, b  8-bit unsigned operands
//   p     16-bit product
module vedic_8X8 (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);

   function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
      logic s1, c1, hi;
      s1 = (x[1] & y[0]) ^ (x[0] & y[1]);
      c1 = (x[1] & y[0]) & (x[0] & y[1]);
      hi = x[1] & y[1];
      return {hi & c1, hi ^ c1, s1, x[0] & y[0]};
   endfunction

   function automatic logic [7:0] vm4(input logic [3:0] x, input logic [3:0] y);
      logic [3:0] q0, q1, q2, q3;
      logic [7:0] mid;
      q0  = vm2(x[1:0], y[1:0]);
      q1  = vm2(x[3:2], y[1:0]);
      q2  = vm2(x[1:0], y[3:2]);
      q3  = vm2(x[3:2], y[3:2]);
      mid = {4'b0, q1} + {4'b0, q2};
      // {q3,q0} places the high and low partial products without an adder.
      return {q3, q0} + (mid << 2);
   endfunction

   logic [7:0]  p0, p1, p2, p3;
   logic [15:0] mid;

   always_comb begin
      p0  = vm4(a[3:0], b[3:0]);
      p1  = vm4(a[7:4], b[3:0]);
      p2  = vm4(a[3:0], b[7:4]);
      p3  = vm4(a[7:4], b[7:4]);
      mid = {8'b0, p1} + {8'b0, p2};
      p   = {p3, p0} + (mid << 4);
   end

endmodule

// File: rtl/vedic_dot_product.sv
// Streaming unsigned dot-product engine.
// One operand pair per cycle is registered (S1), multiplied by vedic_8X8
// and accumulated (S2). The pair flagged in_last closes the vector: its
// sum, element count and wrap flag are loaded into the held result
// registers and the accumulator restarts from zero on the same edge.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         slave side of vedic_dot_product_if (stream in, result out)
module vedic_dot_product
   import vedic_dot_product_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   vedic_dot_product_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic              s1_valid, s1_last;
   logic [OPND_W-1:0] s1_a, s1_b;
   logic [PROD_W-1:0] prod;

   logic [ACC_W-1:0]  acc;
   logic [CNT_W-1:0]  cnt;
   logic              ovf;

   logic              res_valid;
   logic [ACC_W-1:0]  res_sum;
   logic [CNT_W-1:0]  res_count;
   logic              res_ovf;

   logic              s1_adv, in_xfer;
   logic [ACC_W:0]    sum_next;
   logic [CNT_W-1:0]  cnt_inc;

   vedic_8X8 u_mul (
      .a (s1_a),
      .b (s1_b),
      .p (prod)
   );

   // A closing element may only advance if the result slot is free or
   // being drained this cycle; ordinary elements never wait.
   assign s1_adv   = s1_valid & ~(s1_last & res_valid & ~bus.out_ready);
   assign in_xfer  = bus.in_valid & bus.in_ready;
   assign sum_next = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
   assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

   assign bus.in_ready  = ~s1_valid | s1_adv;
   assign bus.out_valid = res_valid;
   assign bus.out_sum   = res_sum;
   assign bus.out_count = res_count;
   assign bus.out_ovf   = res_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else if (in_xfer) begin
         s1_valid <= 1'b1;
         s1_last  <= bus.in_last;
         s1_a     <= bus.in_a;
         s1_b     <= bus.in_b;
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         res_valid <= 1'b0;
         res_sum   <= '0;
         res_count <= '0;
         res_ovf   <= 1'b0;
      end else if (s1_adv && s1_last) begin
         res_valid <= 1'b1;
         res_sum   <= sum_next[ACC_W-1:0];
         res_count <= cnt_inc;
         res_ovf   <= ovf | sum_next[ACC_W];
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
      end else begin
         if (s1_adv) begin
            acc <= sum_next[ACC_W-1:0];
            cnt <= cnt_inc;
            ovf <= ovf | sum_next[ACC_W];
         end
         if (res_valid && bus.out_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vedic_dot_product.sv
// Directed bench for vedic_dot_product. Two engines (ACC_W=24 and ACC_W=16)
// see the same stimulus so wrap behaviour can be compared against the
// wide reference on the same vectors.
module tb_vedic_dot_product;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;

   vedic_dot_product_if #(.ACC_W(24), .CNT_W(8)) bus24 ();
   vedic_dot_product_if #(.ACC_W(16), .CNT_W(8)) bus16 ();

   assign bus16.in_valid  = bus24.in_valid;
   assign bus16.in_a      = bus24.in_a;
   assign bus16.in_b      = bus24.in_b;
   assign bus16.in_last   = bus24.in_last;
   assign bus16.out_ready = bus24.out_ready;

   vedic_dot_product #(.ACC_W(24), .CNT_W(8)) dut24 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus24)
   );

   vedic_dot_product #(.ACC_W(16), .CNT_W(8)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Checks a presented result on both engines.
   task automatic chk_res(input string tag, input int sum24, input int sum16,
                          input int cnt, input int ovf24, input int ovf16);
      chk({tag, " valid24"}, 32'(bus24.out_valid), 1);
      chk({tag, " sum24"},   32'(bus24.out_sum),   sum24);
      chk({tag, " cnt24"},   32'(bus24.out_count), cnt);
      chk({tag, " ovf24"},   32'(bus24.out_ovf),   ovf24);
      chk({tag, " valid16"}, 32'(bus16.out_valid), 1);
      chk({tag, " sum16"},   32'(bus16.out_sum),   sum16);
      chk({tag, " cnt16"},   32'(bus16.out_count), cnt);
      chk({tag, " ovf16"},   32'(bus16.out_ovf),   ovf16);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int a, input int b, input logic last);
      bus24.in_valid = 1'b1;
      bus24.in_a     = 8'(a);
      bus24.in_b     = 8'(b);
      bus24.in_last  = last;
   endtask

   task automatic idle();
      bus24.in_valid = 1'b0;
      bus24.in_last  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus24.in_valid  = 1'b0;
      bus24.in_a      = '0;
      bus24.in_b      = '0;
      bus24.in_last   = 1'b0;
      bus24.out_ready = 1'b1;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst out_valid", 32'(bus24.out_valid), 0);
      chk("rst out_sum",   32'(bus24.out_sum),   0);
      chk("rst out_count", 32'(bus24.out_count), 0);
      chk("rst out_ovf",   32'(bus24.out_ovf),   0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rst in_ready", 32'(bus24.in_ready), 1);

      // single element, one-cycle latency
      drive(255, 255, 1'b1);
      tick();
      idle();
      chk("single latency", 32'(bus24.out_valid), 0);
      tick();
      chk_res("single", 65025, 65025, 1, 0, 0);
      tick();
      chk("single drained", 32'(bus24.out_valid), 0);

      // three-element vector back to back
      drive(3, 4, 1'b0);
      tick();
      chk("vec3 ready0", 32'(bus24.in_ready), 1);
      drive(5, 6, 1'b0);
      tick();
      chk("vec3 ready1", 32'(bus24.in_ready), 1);
      drive(7, 8, 1'b1);
      tick();
      chk("vec3 ready2", 32'(bus24.in_ready), 1);
      idle();
      tick();
      chk_res("vec3", 98, 98, 3, 0, 0);

      // wrap at 16 bits, then a clean vector
      drive(255, 255, 1'b0);
      tick();
      drive(255, 255, 1'b1);
      tick();
      idle();
      tick();
      chk_res("wrap", 130050, 64514, 2, 0, 1);
      drive(2, 3, 1'b1);
      tick();
      idle();
      tick();
      chk_res("after wrap", 6, 6, 1, 0, 0);
      tick();

      // backpressure: A=(1,1), B=(2,2), C=(3,3) offered while stalled
      bus24.out_ready = 1'b0;
      drive(1, 1, 1'b1);
      tick();
      drive(2, 2, 1'b1);
      tick();
      drive(3, 3, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("bp hold valid", 32'(bus24.out_valid), 1);
         chk("bp hold sum",   32'(bus24.out_sum),   1);
         chk("bp in_ready",   32'(bus24.in_ready),  0);
         tick();
      end
      bus24.out_ready = 1'b1;
      tick();
      idle();
      chk_res("bp B", 4, 4, 1, 0, 0);
      tick();
      chk_res("bp C", 9, 9, 1, 0, 0);
      tick();
      chk("bp drained", 32'(bus24.out_valid), 0);

      // reset mid-vector
      drive(10, 10, 1'b0);
      tick();
      drive(10, 10, 1'b0);
      tick();
      idle();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst in_ready", 32'(bus24.in_ready), 1);
      chk("midrst valid",    32'(bus24.out_valid), 0);
      #1 rst_n = 1'b1;
      tick();
      chk("midrst no out", 32'(bus24.out_valid), 0);
      drive(1, 2, 1'b1);
      tick();
      idle();
      chk("midrst latency", 32'(bus24.out_valid), 0);
      tick();
      chk_res("midrst", 2, 2, 1, 0, 0);
      tick();

      // throughput: last on every pair
      for (int i = 1; i <= 8; i++) begin
         drive(i, i, 1'b1);
         tick();
         chk("tp in_ready24", 32'(bus24.in_ready), 1);
         chk("tp in_ready16", 32'(bus16.in_ready), 1);
         if (i > 1) chk_res("tp", (i - 1) * (i - 1), (i - 1) * (i - 1), 1, 0, 0);
         else       chk("tp first", 32'(bus24.out_valid), 0);
      end
      idle();
      tick();
      chk_res("tp last", 64, 64, 1, 0, 0);
      tick();
      chk("tp drained", 32'(bus24.out_valid), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
